lru_tracker: RTL and testbench
==============================

# lru_tracker

Parametrised true-LRU replacement tracker for an N-way set-associative cache. It replaces the fixed 64-set, 2-way LRU bit array with per-set age state and per-way valid bits. It sits beside the cache tag/data arrays. The cache controller reports every hit or fill as a "touch" and every invalidation as an "inval". The controller queries a set to obtain the victim way for the next fill. A multi-cycle flush walks all sets back to the reset state.

## Interface
Parameters:
- NUM_SETS, 64, number of sets; power of 2, ≥2
- WAYS, 4, associativity; power of 2, 2..8
- SET_BITS, $clog2(NUM_SETS), set index width
- WAY_BITS, $clog2(WAYS), way index width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- touch_en  in  1  record access (hit or fill) to touch_set/touch_way
- touch_set  in  SET_BITS  set being accessed
- touch_way  in  WAY_BITS  way being accessed
- inval_en  in  1  invalidate inval_set/inval_way
- inval_set  in  SET_BITS  set to invalidate in
- inval_way  in  WAY_BITS  way to invalidate
- flush  in  1  start full-array flush (single-cycle pulse sufficient)
- query_en  in  1  request victim for query_set
- query_set  in  SET_BITS  set being queried
- victim_vld  out  1  registered; high one cycle after an accepted query
- victim_way  out  WAY_BITS  registered victim way
- victim_evict  out  1  registered; 1 = victim holds valid data (all ways valid)
- busy  out  1  flush in progress; touch/inval/query/flush ignored

## Operation
- Per set, per way: age[WAY_BITS-1:0] and valid bit. Ages in a set are always a permutation of 0..WAYS-1. Age 0 = MRU; WAYS-1 = LRU.
- Reset/flush value: age[w] = WAYS-1-w, so way 0 is LRU. All valid = 0.
- Touch (way t, old age a): every way with age < a increments. Way t age := 0. valid[t] := 1. Touching the current MRU changes no ages.
- Inval (way i, old age a): every way with age > a decrements. Way i age := WAYS-1. valid[i] := 0. Inval of an already-invalid way still applies the age update.
- Victim: lowest-index invalid way if any (victim_evict=0). Otherwise the way with age WAYS-1 (victim_evict=1).
- Touch and inval to different sets in the same cycle: both applied.
- Touch and inval to the same set in the same cycle: touch applied, inval dropped.
- Query in the same cycle as a touch or inval to the same set: the victim reflects pre-update state.
- FSM states: IDLE and FLUSH.
  - IDLE → FLUSH on flush. Flush counter cleared to 0.
  - FLUSH: one set per cycle, counter 0..NUM_SETS-1, each set written to its reset value.
  - FLUSH → IDLE after set NUM_SETS-1. The counter wraps to 0.
- busy = (state == FLUSH). While busy, touch_en, inval_en, query_en and flush are ignored and no victim_vld is produced.

## Timing
- Touch and inval take effect at the next rising edge. A query in the following cycle sees the new state.
- Query latency: exactly 1 cycle. victim_vld pulses for one cycle per accepted query. Back-to-back queries give back-to-back results.
- Flush: busy rises the cycle after the flush pulse and stays high exactly NUM_SETS cycles. Inputs are accepted again in the first cycle busy = 0.
- Reset values: victim_vld=0, victim_way=0, victim_evict=0, busy=0, FSM=IDLE, all sets at reset value.
- rst asserted mid-flush: next cycle FSM=IDLE, busy=0, all sets at reset value. rst has priority over every other input.

## Structure
- Shared package/header lru_defs: default NUM_SETS/WAYS, FSM state encodings (ST_IDLE, ST_FLUSH), and a reset-age function age_init(w) = WAYS-1-w.
- Sub-module lru_set, instantiated NUM_SETS times:
  - holds one set's ages and valids;
  - takes decoded touch/inval/clear strobes;
  - outputs a combinational victim_way/victim_evict.
- Top level contains the set decoders, same-set priority, flush FSM/counter, and the registered query mux.

## Test plan
- Reset, then query set 5: next cycle victim_vld=1, victim_way=0, victim_evict=0, busy=0.
- WAYS=4, touch set 3 ways 0,1,2,3 in order, then query set 3: victim_way=0, evict=1. Touch way 0 and query again: victim_way=1, evict=1.
- From the full set 3 above, inval way 2: query gives victim_way=2, evict=0. Touch way 2 and query: victim_way=1, evict=1.
- Same cycle, touch set 7 way 1 and inval set 7 way 1: way 1 stays valid, inval dropped. Touch set 7 with inval set 8 in the same cycle: both applied.
- Fill several sets, then pulse flush: busy high exactly 64 cycles. Touches and queries during flush produce no effect and no victim_vld. Afterwards, every set queries victim_way=0, evict=0.
- Pulse flush, assert rst at flush cycle 10: busy=0 the next cycle. A query of set 20 returns victim_way=0, evict=0.

Source files
------------

// File: rtl/lru_tracker_pkg.sv
// Shared definitions for the LRU tracker: default geometry, flush FSM states
// and the reset age of each way.
package lru_defs;

  localparam int unsigned LRU_NUM_SETS_DEF = 64;
  localparam int unsigned LRU_WAYS_DEF     = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } lru_state_t;

  // Reset/flush age of way w: way 0 starts as LRU, way WAYS-1 as MRU.
  function automatic int unsigned age_init(input int unsigned ways,
                                           input int unsigned w);
    return ways - 1 - w;
  endfunction

endpackage

// File: rtl/lru_set.sv
// One set of the LRU tracker: per-way ages and valid bits, updated by decoded
// touch/inval/clear strobes, with a combinational victim selection.
module lru_set
  import lru_defs::*;
#(
  parameter int unsigned WAYS     = LRU_WAYS_DEF,
  parameter int unsigned WAY_BITS = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_touch,
  input  logic [WAY_BITS-1:0] i_touch_way,
  input  logic                i_inval,
  input  logic [WAY_BITS-1:0] i_inval_way,
  output logic [WAY_BITS-1:0] o_victim_way,
  output logic                o_victim_evict
);

  logic [WAYS-1:0][WAY_BITS-1:0] r_age;
  logic [WAYS-1:0]               r_valid;
  logic [WAYS-1:0][WAY_BITS-1:0] w_age_nxt;
  logic [WAYS-1:0]               w_valid_nxt;
  logic [WAY_BITS-1:0]           w_ref_age;
  logic [WAY_BITS-1:0]           w_free_way;
  logic [WAY_BITS-1:0]           w_lru_way;
  logic                          w_found;

  // Next ages/valids: touch promotes to MRU, inval demotes to LRU; touch wins.
  always_comb begin
    w_age_nxt   = r_age;
    w_valid_nxt = r_valid;
    w_ref_age   = '0;
    if (i_touch) begin
      w_ref_age = r_age[i_touch_way];
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_BITS'(w) == i_touch_way)
          w_age_nxt[w] = '0;
        else if (r_age[w] < w_ref_age)
          w_age_nxt[w] = r_age[w] + 1'b1;
      end
      w_valid_nxt[i_touch_way] = 1'b1;
    end else if (i_inval) begin
      w_ref_age = r_age[i_inval_way];
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_BITS'(w) == i_inval_way)
          w_age_nxt[w] = '1;
        else if (r_age[w] > w_ref_age)
          w_age_nxt[w] = r_age[w] - 1'b1;
      end
      w_valid_nxt[i_inval_way] = 1'b0;
    end
  end

  // Age/valid state register; reset and flush clear restore the initial order.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      for (int unsigned w = 0; w < WAYS; w++)
        r_age[w] <= WAY_BITS'(age_init(WAYS, w));
      r_valid <= '0;
    end else begin
      r_age   <= w_age_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Victim: lowest-index invalid way, else the way holding the oldest age.
  always_comb begin
    w_found    = 1'b0;
    w_free_way = '0;
    w_lru_way  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!r_valid[w] && !w_found) begin
        w_free_way = WAY_BITS'(w);
        w_found    = 1'b1;
      end
      if (r_age[w] == '1)
        w_lru_way = WAY_BITS'(w);
    end
    o_victim_evict = &r_valid;
    o_victim_way   = (&r_valid) ? w_lru_way : w_free_way;
  end

endmodule

// File: rtl/lru_tracker.sv
// True-LRU replacement tracker for an N-way set-associative cache: set
// decoders, same-set touch/inval priority, flush FSM and registered query mux.
module lru_tracker
  import lru_defs::*;
#(
  parameter int unsigned NUM_SETS = LRU_NUM_SETS_DEF,
  parameter int unsigned WAYS     = LRU_WAYS_DEF,
  parameter int unsigned SET_BITS = $clog2(NUM_SETS),
  parameter int unsigned WAY_BITS = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                touch_en,
  input  logic [SET_BITS-1:0] touch_set,
  input  logic [WAY_BITS-1:0] touch_way,
  input  logic                inval_en,
  input  logic [SET_BITS-1:0] inval_set,
  input  logic [WAY_BITS-1:0] inval_way,
  input  logic                flush,
  input  logic                query_en,
  input  logic [SET_BITS-1:0] query_set,
  output logic                victim_vld,
  output logic [WAY_BITS-1:0] victim_way,
  output logic                victim_evict,
  output logic                busy
);

  lru_state_t          r_state;
  lru_state_t          w_state_nxt;
  logic [SET_BITS-1:0] r_cnt;
  logic [SET_BITS-1:0] w_cnt_nxt;

  logic                r_victim_vld;
  logic [WAY_BITS-1:0] r_victim_way;
  logic                r_victim_evict;

  logic                w_busy;
  logic                w_touch_go;
  logic                w_inval_go;
  logic                w_query_go;

  logic [NUM_SETS-1:0] w_set_touch;
  logic [NUM_SETS-1:0] w_set_inval;
  logic [NUM_SETS-1:0] w_set_clear;
  logic [WAY_BITS-1:0] w_set_vway [NUM_SETS];
  logic [NUM_SETS-1:0] w_set_evict;

  assign w_busy     = (r_state == ST_FLUSH);
  assign w_touch_go = touch_en && !w_busy;
  // A same-set inval is dropped in favour of the concurrent touch.
  assign w_inval_go = inval_en && !w_busy && !(w_touch_go && (inval_set == touch_set));
  assign w_query_go = query_en && !w_busy;

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    assign w_set_touch[s] = w_touch_go && (touch_set == SET_BITS'(s));
    assign w_set_inval[s] = w_inval_go && (inval_set == SET_BITS'(s));
    assign w_set_clear[s] = w_busy && (r_cnt == SET_BITS'(s));

    lru_set #(
      .WAYS     (WAYS),
      .WAY_BITS (WAY_BITS)
    ) u_set (
      .clk            (clk),
      .rst            (rst),
      .i_clear        (w_set_clear[s]),
      .i_touch        (w_set_touch[s]),
      .i_touch_way    (touch_way),
      .i_inval        (w_set_inval[s]),
      .i_inval_way    (inval_way),
      .o_victim_way   (w_set_vway[s]),
      .o_victim_evict (w_set_evict[s])
    );
  end

  // Flush FSM state and set counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Flush FSM next state: walk one set per cycle, leave after the last set.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (flush) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = '0;
        end
      end
      ST_FLUSH: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == SET_BITS'(NUM_SETS - 1))
          w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Registered query result, sampled from pre-update set state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_victim_vld   <= 1'b0;
      r_victim_way   <= '0;
      r_victim_evict <= 1'b0;
    end else begin
      r_victim_vld <= w_query_go;
      if (w_query_go) begin
        r_victim_way   <= w_set_vway[query_set];
        r_victim_evict <= w_set_evict[query_set];
      end
    end
  end

  assign victim_vld   = r_victim_vld;
  assign victim_way   = r_victim_way;
  assign victim_evict = r_victim_evict;
  assign busy         = w_busy;

endmodule

// File: tb/tb_lru_tracker.sv
// Directed self-checking bench for lru_tracker (64 sets, 4 ways).
module tb_lru_tracker;

  localparam int unsigned NUM_SETS = 64;
  localparam int unsigned WAYS     = 4;
  localparam int unsigned SET_BITS = 6;
  localparam int unsigned WAY_BITS = 2;

  logic                clk;
  logic                rst;
  logic                touch_en;
  logic [SET_BITS-1:0] touch_set;
  logic [WAY_BITS-1:0] touch_way;
  logic                inval_en;
  logic [SET_BITS-1:0] inval_set;
  logic [WAY_BITS-1:0] inval_way;
  logic                flush;
  logic                query_en;
  logic [SET_BITS-1:0] query_set;
  logic                victim_vld;
  logic [WAY_BITS-1:0] victim_way;
  logic                victim_evict;
  logic                busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  lru_tracker #(
    .NUM_SETS (NUM_SETS),
    .WAYS     (WAYS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .touch_en     (touch_en),
    .touch_set    (touch_set),
    .touch_way    (touch_way),
    .inval_en     (inval_en),
    .inval_set    (inval_set),
    .inval_way    (inval_way),
    .flush        (flush),
    .query_en     (query_en),
    .query_set    (query_set),
    .victim_vld   (victim_vld),
    .victim_way   (victim_way),
    .victim_evict (victim_evict),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic touch(input int unsigned s, input int unsigned w);
    touch_en  = 1'b1;
    touch_set = SET_BITS'(s);
    touch_way = WAY_BITS'(w);
    tick();
    touch_en  = 1'b0;
  endtask

  task automatic inval(input int unsigned s, input int unsigned w);
    inval_en  = 1'b1;
    inval_set = SET_BITS'(s);
    inval_way = WAY_BITS'(w);
    tick();
    inval_en  = 1'b0;
  endtask

  task automatic query(input string tag, input int unsigned s,
                       input int unsigned exp_way, input int unsigned exp_evict);
    query_en  = 1'b1;
    query_set = SET_BITS'(s);
    tick();
    query_en  = 1'b0;
    chk({tag, "_vld"},   32'(victim_vld),   32'd1);
    chk({tag, "_way"},   32'(victim_way),   exp_way);
    chk({tag, "_evict"}, 32'(victim_evict), exp_evict);
  endtask

  initial begin
    int unsigned n;
    int unsigned bad_vld;

    rst = 1'b1; touch_en = 1'b0; touch_set = '0; touch_way = '0;
    inval_en = 1'b0; inval_set = '0; inval_way = '0;
    flush = 1'b0; query_en = 1'b0; query_set = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_vld",   32'(victim_vld),   32'd0);
    chk("rst_way",   32'(victim_way),   32'd0);
    chk("rst_evict", 32'(victim_evict), 32'd0);
    chk("rst_busy",  32'(busy),         32'd0);

    query("q5", 5, 0, 0);
    chk("q5_busy", 32'(busy), 32'd0);
    tick();
    chk("vld_one_shot", 32'(victim_vld), 32'd0);

    // Fill set 3 in order: way 0 becomes LRU.
    for (int unsigned w = 0; w < WAYS; w++) touch(3, w);
    query("s3_full", 3, 0, 1);
    touch(3, 0);
    query("s3_t0", 3, 1, 1);
    inval(3, 2);
    query("s3_inv2", 3, 2, 0);
    touch(3, 2);
    query("s3_t2", 3, 1, 1);

    // Query alongside a touch of the same set sees the old state.
    query_en = 1'b1; query_set = 6'd3;
    touch(3, 1);
    query_en = 1'b0;
    chk("qt_same_vld", 32'(victim_vld), 32'd1);
    chk("qt_same_way", 32'(victim_way), 32'd1);
    query("s3_after_t1", 3, 3, 1);

    // Same-set touch+inval: touch kept, inval dropped.
    touch_en = 1'b1; touch_set = 6'd7; touch_way = 2'd1;
    inval_en = 1'b1; inval_set = 6'd7; inval_way = 2'd1;
    tick();
    touch_en = 1'b0; inval_en = 1'b0;
    touch(7, 0); touch(7, 2); touch(7, 3);
    query("s7_same", 7, 1, 1);

    // Different-set touch+inval: both applied.
    touch(8, 0);
    query("s8_pre", 8, 1, 0);
    touch_en = 1'b1; touch_set = 6'd7; touch_way = 2'd1;
    inval_en = 1'b1; inval_set = 6'd8; inval_way = 2'd0;
    tick();
    touch_en = 1'b0; inval_en = 1'b0;
    query("s7_diff", 7, 0, 1);
    query("s8_diff", 8, 0, 0);

    // Flush with touches and queries hammering during busy.
    touch(40, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy_rise", 32'(busy), 32'd1);
    touch_en = 1'b1; touch_set = 6'd3; touch_way = 2'd0;
    query_en = 1'b1; query_set = 6'd3;
    flush = 1'b1;
    n = 0; bad_vld = 0;
    while (busy && n < 200) begin
      tick();
      n++;
      if (victim_vld) bad_vld++;
    end
    touch_en = 1'b0; query_en = 1'b0; flush = 1'b0;
    chk("flush_len", n, 32'd64);
    chk("flush_no_vld", bad_vld, 32'd0);
    for (int unsigned s = 0; s < NUM_SETS; s++) query($sformatf("post_flush_s%0d", s), s, 0, 0);
    chk("post_flush_busy", 32'(busy), 32'd0);

    // Reset in the middle of a flush.
    touch(20, 0);
    query("s20_pre", 20, 1, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int unsigned i = 0; i < 10; i++) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_vld",  32'(victim_vld), 32'd0);
    query("s20_rst", 20, 0, 0);
    tick();
    chk("idle_after_rst", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
